// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
//   state_t  : arbiter FSM state encoding (IDLE / EXEC / RESP)
//   req_id_t : requester identifier
//   OP_*     : ALU opcode constants, OP_NOP means "no ALU operation"
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOR = 3'b111;

  // ALUControl value driven out of reset
  localparam logic [2:0] ALUCTL_RESET = OP_ADD;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the external shared ALU.
//   Req{0,1}{Valid,Ready,A,B,Op} : request channel per requester
//   Resp{0,1}{Valid,Ready,Data}  : response channel per requester
//   DR1, DR2, ALUControl         : operands/opcode driven to the ALU
//   ALUOutput                    : combinational ALU result
//   Busy, Grant{0,1}Count        : status
// Modports: slave = arbiter side, master = requester/ALU side.
interface alu_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             Req0Valid, Req1Valid;
  logic             Req0Ready, Req1Ready;
  logic [31:0]      Req0A, Req1A, Req0B, Req1B;
  logic [2:0]       Req0Op, Req1Op;
  logic             Resp0Valid, Resp1Valid;
  logic             Resp0Ready, Resp1Ready;
  logic [31:0]      Resp0Data, Resp1Data;
  logic [31:0]      DR1, DR2;
  logic [2:0]       ALUControl;
  logic [31:0]      ALUOutput;
  logic             Busy;
  logic [CNT_W-1:0] Grant0Count, Grant1Count;

  modport slave (
    input  Req0Valid, Req1Valid, Req0A, Req1A, Req0B, Req1B, Req0Op, Req1Op,
    input  Resp0Ready, Resp1Ready, ALUOutput,
    output Req0Ready, Req1Ready, Resp0Valid, Resp1Valid, Resp0Data, Resp1Data,
    output DR1, DR2, ALUControl, Busy, Grant0Count, Grant1Count
  );

  modport master (
    output Req0Valid, Req1Valid, Req0A, Req1A, Req0B, Req1B, Req0Op, Req1Op,
    output Resp0Ready, Resp1Ready, ALUOutput,
    input  Req0Ready, Req1Ready, Resp0Valid, Resp1Valid, Resp0Data, Resp1Data,
    input  DR1, DR2, ALUControl, Busy, Grant0Count, Grant1Count
  );
endinterface

// File: rtl/alu_arb_pick.sv
// Combinational winner selection between two requesters.
//   v0, v1     : requester valid
//   last       : requester granted last (round-robin build only)
//   gnt0, gnt1 : one-hot winner, both low when nothing is valid
// Macro ALU_ARB_ROUND_ROBIN_EN: ties go to the requester not granted last;
// otherwise requester 0 always wins ties.
module alu_arb_pick
  import alu_arbiter_pkg::*;
(
  input  logic    v0,
  input  logic    v1,
`ifdef ALU_ARB_ROUND_ROBIN_EN
  input  req_id_t last,
`endif
  output logic    gnt0,
  output logic    gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (v0 && v1) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      if (last == REQ0) gnt1 = 1'b1;
      else              gnt0 = 1'b1;
`else
      gnt0 = 1'b1;
`endif
    end else begin
      gnt0 = v0;
      gnt1 = v1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared, externally instantiated ALU.
// One operation at a time: IDLE (arbitrate/accept) -> EXEC (drive ALU,
// capture result) -> RESP (return result to owner until handshake).
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : alu_arbiter_if.slave (request/response channels, ALU drive, status)
// Parameter CNT_W: width of the saturating per-requester grant counters.
// Macro ALU_ARB_ROUND_ROBIN_EN: enables round-robin tie breaking with a
// last-grant register; without it requester 0 has fixed priority.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  state_t           state_q, state_d;
  req_id_t          owner_q;
  req_id_t          win;
  logic [2:0]       op_q;
  logic [31:0]      dr1_q, dr2_q, result_q;
  logic [2:0]       aluctl_q;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  logic             gnt0, gnt1;
  logic             rdy0, rdy1, rv0, rv1;
  logic             accept;
  logic [31:0]      win_a, win_b;
  logic [2:0]       win_op;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  req_id_t last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_q <= REQ1;
    else if (accept) last_q <= win;
  end
`endif

  alu_arb_pick u_pick (
    .v0   (bus.Req0Valid),
    .v1   (bus.Req1Valid),
`ifdef ALU_ARB_ROUND_ROBIN_EN
    .last (last_q),
`endif
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  // Winner's request fields; only meaningful while accepting
  always_comb begin
    win    = gnt1 ? REQ1 : REQ0;
    win_a  = gnt1 ? bus.Req1A  : bus.Req0A;
    win_b  = gnt1 ? bus.Req1B  : bus.Req0B;
    win_op = gnt1 ? bus.Req1Op : bus.Req0Op;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    rv0     = 1'b0;
    rv1     = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdy0 = gnt0;
        rdy1 = gnt1;
        if (gnt0 || gnt1) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rv0 = (owner_q == REQ0);
        rv1 = (owner_q == REQ1);
        if ((rv0 && bus.Resp0Ready) || (rv1 && bus.Resp1Ready)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants are only issued to valid requesters, so Ready alone marks an accept
  assign accept = rdy0 | rdy1;

  // DR1/DR2 double as the operand latches: loaded at accept, they present the
  // operands throughout EXEC and simply hold afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q  <= REQ0;
      op_q     <= OP_NOP;
      dr1_q    <= '0;
      dr2_q    <= '0;
      aluctl_q <= ALUCTL_RESET;
      result_q <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      if (accept) begin
        owner_q <= win;
        op_q    <= win_op;
        dr1_q   <= win_a;
        dr2_q   <= win_b;
        // NOP leaves the ALU opcode untouched
        if (win_op != OP_NOP) aluctl_q <= win_op;
      end
      if (state_q == EXEC) result_q <= (op_q == OP_NOP) ? '0 : bus.ALUOutput;
      if (rdy0 && (cnt0_q != '1)) cnt0_q <= cnt0_q + 1'b1;
      if (rdy1 && (cnt1_q != '1)) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign bus.Req0Ready   = rdy0;
  assign bus.Req1Ready   = rdy1;
  assign bus.Resp0Valid  = rv0;
  assign bus.Resp1Valid  = rv1;
  assign bus.Resp0Data   = result_q;
  assign bus.Resp1Data   = result_q;
  assign bus.DR1         = dr1_q;
  assign bus.DR2         = dr2_q;
  assign bus.ALUControl  = aluctl_q;
  assign bus.Busy        = (state_q != IDLE);
  assign bus.Grant0Count = cnt0_q;
  assign bus.Grant1Count = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: cycle-level reference model of the
// arbitration/handshake rules plus a response scoreboard. Counters use a
// narrow CNT_W so saturation is reached quickly.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_arbiter_if #(.CNT_W(CNT_W)) bus ();
  alu_arbiter #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_NOP:  return 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // External shared ALU
  always_comb bus.ALUOutput = alu_f(bus.ALUControl, bus.DR1, bus.DR2);

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  // Requester stimulus state
  bit          pv [2];
  logic [2:0]  pop [2];
  logic [31:0] pa [2], pb [2];
  bit          rr [2];

  // Reference model state
  bit          m_idle, m_exec, m_owner, m_last;
  logic [31:0] m_dr1, m_dr2;
  logic [2:0]  m_ctl;
  int          m_cnt [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input bit v0, input bit v1);
    if (v0 && v1) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      return m_last ? 0 : 1;
`else
      return 0;
`endif
    end
    return v0 ? 0 : (v1 ? 1 : -1);
  endfunction

  task automatic model_reset();
    m_idle = 1; m_exec = 0; m_owner = 0; m_last = 1;
    m_dr1 = '0; m_dr2 = '0; m_ctl = 3'b001;
    m_cnt[0] = 0; m_cnt[1] = 0;
    pv[0] = 0; pv[1] = 0;
    sbq.delete();
  endtask

  task automatic drive();
    bus.Req0Valid = pv[0]; bus.Req0Op = pop[0]; bus.Req0A = pa[0]; bus.Req0B = pb[0];
    bus.Req1Valid = pv[1]; bus.Req1Op = pop[1]; bus.Req1A = pa[1]; bus.Req1B = pb[1];
    bus.Resp0Ready = rr[0]; bus.Resp1Ready = rr[1];
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    pv[i] = 1; pop[i] = op; pa[i] = a; pb[i] = b;
  endtask

  task automatic refill(input int i);
    if (!pv[i]) set_req(i, 3'($urandom_range(0, 7)), $urandom, $urandom);
  endtask

  task automatic reset_checks();
    check("rst_dr1", bus.DR1, 32'd0);
    check("rst_dr2", bus.DR2, 32'd0);
    check("rst_aluctl", 32'(bus.ALUControl), 32'd1);
    check("rst_cnt0", 32'(bus.Grant0Count), 32'd0);
    check("rst_cnt1", 32'(bus.Grant1Count), 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_resp0_valid", 32'(bus.Resp0Valid), 32'd0);
    check("rst_resp1_valid", 32'(bus.Resp1Valid), 32'd0);
    check("rst_resp0_data", bus.Resp0Data, 32'd0);
    check("rst_resp1_data", bus.Resp1Data, 32'd0);
  endtask

  // One clock: drive inputs, compare outputs mid-cycle, then advance the model
  task automatic step();
    int w;
    bit rv, hs;
    drive();
    @(negedge clk);
    w  = m_idle ? pick(pv[0], pv[1]) : -1;
    rv = !m_idle && !m_exec;
    hs = rv && rr[m_owner];
    check("req0_ready", 32'(bus.Req0Ready), 32'(w == 0));
    check("req1_ready", 32'(bus.Req1Ready), 32'(w == 1));
    check("busy", 32'(bus.Busy), 32'(!m_idle));
    check("resp0_valid", 32'(bus.Resp0Valid), 32'(rv && !m_owner));
    check("resp1_valid", 32'(bus.Resp1Valid), 32'(rv && m_owner));
    check("dr1", bus.DR1, m_dr1);
    check("dr2", bus.DR2, m_dr2);
    check("aluctl", 32'(bus.ALUControl), 32'(m_ctl));
    check("cnt0", 32'(bus.Grant0Count), 32'(m_cnt[0]));
    check("cnt1", 32'(bus.Grant1Count), 32'(m_cnt[1]));
    @(posedge clk);
    #1;
    if (w >= 0) begin
      sbq.push_back('{id: w[0], data: alu_f(pop[w], pa[w], pb[w])});
      m_dr1 = pa[w]; m_dr2 = pb[w];
      if (pop[w] != 3'b000) m_ctl = pop[w];
      if (m_cnt[w] < CMAX) m_cnt[w]++;
      m_last = w[0]; m_owner = w[0];
      m_idle = 0; m_exec = 1;
      // Request fields change after acceptance; must not disturb the operation
      pv[w] = 0; pa[w] = $urandom; pb[w] = $urandom; pop[w] = 3'($urandom_range(0, 7));
    end else if (m_exec) begin
      m_exec = 0;
    end else if (hs) begin
      m_idle = 1;
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && !m_idle; k++) step();
    check("reached_idle", 32'(m_idle), 32'd1);
  endtask

  // Response monitor: pop expected on each handshake, verify hold while stalled
  logic [31:0] held [2];
  bit          holding [2];

  task automatic mon(input int id, input logic v, input logic r, input logic [31:0] d);
    exp_t e;
    if (!v) begin holding[id] = 0; return; end
    if (holding[id]) check("resp_stable", d, held[id]);
    if (r) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected: got response on requester %0d expected none", id);
      end else begin
        e = sbq.pop_front();
        check("resp_owner", 32'(id), 32'(e.id));
        check("resp_data", d, e.data);
      end
      holding[id] = 0;
    end else begin
      holding[id] = 1;
      held[id]    = d;
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (reset) begin
      holding[0] = 0; holding[1] = 0;
    end else begin
      if (bus.Resp0Valid && bus.Resp1Valid) check("resp_onehot", 32'd2, 32'd1);
      mon(0, bus.Resp0Valid, bus.Resp0Ready, bus.Resp0Data);
      mon(1, bus.Resp1Valid, bus.Resp1Ready, bus.Resp1Data);
    end
  end

  initial begin
    reset = 1'b1;
    pop[0] = '0; pop[1] = '0; pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0;
    rr[0] = 1; rr[1] = 1;
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    reset = 1'b0;

    // Single ADD 5+7 from requester 0
    set_req(0, OP_ADD, 32'd5, 32'd7);
    repeat (5) step();

    // Both requesters continuously valid
    for (int k = 0; k < 16; k++) begin refill(0); refill(1); step(); end
    pv[0] = 0; pv[1] = 0;
    wait_idle();

    // SUB 3-5 from requester 1 with a 4-cycle response stall, requester 0 waiting
    set_req(1, OP_SUB, 32'd3, 32'd5);
    rr[1] = 0;
    repeat (2) step();
    set_req(0, OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    repeat (4) step();
    rr[1] = 1;
    repeat (6) step();
    wait_idle();

    // NOP with A=B=9: result zero, ALUControl keeps prior opcode
    set_req(0, OP_NOP, 32'd9, 32'd9);
    repeat (5) step();
    wait_idle();

    // Reset while in EXEC
    set_req(0, OP_XOR, $urandom, $urandom);
    step();
    #2 reset = 1'b1;
    #1;
    reset_checks();
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    set_req(1, OP_OR, 32'h1234_0000, 32'h0000_5678);
    repeat (5) step();
    wait_idle();

    // Drive requester 0 past counter saturation
    for (int k = 0; k < 80; k++) begin refill(0); step(); end
    pv[0] = 0;
    wait_idle();

    // Random traffic: random issue, withdrawal and response back-pressure
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) refill(i);
        else if (pv[i] && $urandom_range(0, 15) == 0) pv[i] = 0;
        rr[i] = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    pv[0] = 0; pv[1] = 0; rr[0] = 1; rr[1] = 1;
    repeat (10) step();
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    check("final_idle", 32'(m_idle), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter SHALL be: CNT_W, 16, width of each per-requester grant counter.
REQ-002 Port SHALL be: clk  in  1  single clock, all state on rising edge.
REQ-003 Port SHALL be: reset  in  1  asynchronous, active-high reset.
REQ-004 Ports SHALL be: Req0Valid/Req1Valid  in  1  requester n has an operation pending.
REQ-005 Ports SHALL be: Req0Ready/Req1Ready  out  1  requester n's operation accepted this cycle.
REQ-006 Ports SHALL be: Req0A/Req1A, Req0B/Req1B  in  32  operand A / operand B of requester n.
REQ-007 Ports SHALL be: Req0Op/Req1Op  in  3  ALU opcode (001 ADD, 010 SUB, 011 SLT, 100 AND, 101 OR, 110 XOR, 111 NOR, 000 NOP).
REQ-008 Ports SHALL be: Resp0Valid/Resp1Valid  out  1; Resp0Ready/Resp1Ready  in  1; Resp0Data/Resp1Data  out  32  result return to requester n.
REQ-009 Ports SHALL be: DR1, DR2  out  32; ALUControl  out  3  drive the shared ALU; ALUOutput  in  32  ALU combinational result.
REQ-010 Ports SHALL be: Busy  out  1  FSM not idle; Grant0Count/Grant1Count  out  CNT_W  accepted-operation counts.

Function
REQ-011 FSM SHALL have states IDLE, EXEC, RESP; IDLE->EXEC on accept, EXEC->RESP unconditionally, RESP->IDLE on response handshake.
REQ-012 In IDLE, exactly one ReqnReady SHALL be high: the arbitration winner among valid requesters; none if neither valid; both low outside IDLE.
REQ-013 Accept (ReqnValid & ReqnReady) SHALL latch A, B, Op and owner id; requester values may change afterwards without effect.
REQ-014 In EXEC, DR1/DR2/ALUControl SHALL equal the latched A/B/Op, and ALUOutput SHALL be registered into the result register at that cycle's end.
REQ-015 Outside EXEC, DR1/DR2/ALUControl SHALL hold their last driven values.
REQ-016 Op 000 SHALL be accepted, ALUControl SHALL stay at its previous value, and result SHALL be 32'h0.
REQ-017 In RESP, only the owner's RespnValid SHALL be high, with RespnData stable until RespnReady is sampled high.
REQ-018 Latency SHALL be: accept edge N, EXEC cycle N+1, RespnValid from cycle N+2; next accept earliest the cycle after the response handshake.
REQ-019 Deasserting ReqnValid before acceptance SHALL have no effect and SHALL NOT be an error.
REQ-020 GrantnCount SHALL increment on each accept by requester n and saturate at all-ones.
REQ-021 Busy SHALL be high in EXEC and RESP.

Reset
REQ-022 On reset, the block SHALL immediately enter IDLE, abandon any in-flight operation and drive these values: Resp*Valid=0, Resp*Data=0, DR1=DR2=0, ALUControl=3'b001, counters=0, last-grant=1.

Configuration
REQ-023 With ALU_ARB_ROUND_ROBIN_EN defined, when both are valid, the requester not granted last SHALL win, and last-grant SHALL update on each accept.
REQ-024 Without ALU_ARB_ROUND_ROBIN_EN, Req0 SHALL always win ties, and the last-grant register SHALL be absent.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding, ALU opcode constants (including NOP 3'b000) and the requester id type.
REQ-026 One sub-module, alu_arb_pick, SHALL hold the combinational winner selection; the ALU itself SHALL be instantiated outside this block.

Verification
REQ-027 Req0 ADD A=5 B=7 alone: Req0Ready at edge N, ALUControl=001 in N+1, Resp0Valid from N+2 with Resp0Data=12, Grant0Count=1.
REQ-028 Both valid from reset with RR: grants SHALL be Req0, Req1, Req0, Req1; without macro, four grants to Req0 while Req0 stays valid.
REQ-029 Req1 SUB A=3 B=5 with Resp1Ready low 4 cycles: Resp1Data=32'hFFFFFFFE held stable, no new Ready until handshake.
REQ-030 Req0 Op=000 A=9 B=9: Resp0Data=0, ALUControl unchanged from prior op.
REQ-031 Reset asserted in EXEC: outputs reach reset values without a clock edge, and the next request completes normally.
REQ-032 Force Grant0Count to all-ones, then accept: count SHALL stay all-ones.
